// File: rtl/scan_test_ctrl_if.sv
// Pin bundle between the scan command engine, the board UART
// and the scan-testable DUT.
interface scan_test_ctrl_if #(
  parameter int NCHAINS = 1
);
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic               tx_ready;
  logic               dut_clk;
  logic               dut_rstn;
  logic               dut_se;
  logic               dut_tm;
  logic [NCHAINS-1:0] dut_si;
  logic [NCHAINS-1:0] dut_so;
  logic               busy;
  logic               err;

  modport master (
    input  rx_data, rx_valid, tx_ready, dut_so,
    output tx_data, tx_start, dut_clk, dut_rstn,
    output dut_se, dut_tm, dut_si, busy, err
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, dut_so,
    input  tx_data, tx_start, dut_clk, dut_rstn,
    input  dut_se, dut_tm, dut_si, busy, err
  );
endinterface

// File: rtl/scan_test_ctrl.sv
// UART byte command engine: DUT reset, N-cycle run, free run,
// multi-chain scan load and recirculating hex scan dump.
module scan_test_ctrl #(
  parameter int NCHAINS    = 1,
  parameter int CLK_DIV    = 1,
  parameter int MAX_COLS   = 70,
  parameter int RST_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rstn,
  scan_test_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_DRST, S_IDLE, S_CNT_HI, S_CNT_LO,
    S_RUN, S_FREE, S_SIN_WAIT, S_SIN_CYC,
    S_SOUT_CYC, S_SOUT_NEXT,
    S_TX_WAIT, S_TX_HOLD, S_TX_DONE
  } state_t;

  typedef enum logic [1:0] {
    C_RUN, C_SIN, C_SOUT
  } cmd_t;

  localparam int PW = $clog2(2*CLK_DIV) + 1;
  localparam logic [PW-1:0] PC_ONE  = PW'(1);
  localparam logic [PW-1:0] PC_SAMP = PW'(CLK_DIV-1);
  localparam logic [PW-1:0] PC_HI   = PW'(CLK_DIV);
  localparam logic [PW-1:0] PC_LAST = PW'(2*CLK_DIV-1);
  localparam logic [15:0]   RC_LAST = 16'(RST_CYCLES-1);
  localparam logic [7:0]    COL_MAX = 8'(MAX_COLS);

  localparam logic [7:0] CH_R  = 8'h72;
  localparam logic [7:0] CH_O  = 8'h6F;
  localparam logic [7:0] CH_S  = 8'h73;
  localparam logic [7:0] CH_G  = 8'h67;
  localparam logic [7:0] CH_F  = 8'h66;
  localparam logic [7:0] CH_D  = 8'h64;
  localparam logic [7:0] CH_K  = 8'h4B;
  localparam logic [7:0] CH_NL = 8'h0A;

  state_t state_q, state_d;
  state_t ret_q, ret_d;
  cmd_t   cmd_q, cmd_d;

  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        rc_q, rc_d;
  logic [PW-1:0]      pc_q, pc_d;
  logic [7:0]         col_q, col_d;
  logic [NCHAINS-1:0] so_q, so_d;
  logic               stop_q, stop_d;
  logic               rack_q, rack_d;

  logic [7:0]         txd_q, txd_d;
  logic               txs_q, txs_d;
  logic               dclk_q, dclk_d;
  logic               drstn_q, drstn_d;
  logic               se_q, se_d;
  logic               tm_q, tm_d;
  logic [NCHAINS-1:0] si_q, si_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic [3:0]    so_x;
  logic          cyc_end;
  logic [PW-1:0] pc_inc;
  logic          rx_d_cmd;
  logic          cyc_st;
  logic [15:0]   n_new;

  function automatic logic [7:0] hex(input logic [3:0] v);
    return (v < 4'd10) ? 8'h30 + {4'h0, v}
                       : 8'h37 + {4'h0, v};
  endfunction

  always_comb begin
    so_x = '0;
    so_x[NCHAINS-1:0] = so_q;
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    rc_d    = rc_q;
    pc_d    = pc_q;
    col_d   = col_q;
    so_d    = so_q;
    stop_d  = stop_q;
    rack_d  = rack_q;
    txd_d   = txd_q;
    txs_d   = txs_q;
    si_d    = si_q;
    err_d   = 1'b0;
    n_new   = {cnt_q[15:8], bus.rx_data};

    cyc_end  = (pc_q == PC_LAST);
    pc_inc   = cyc_end ? '0 : pc_q + PC_ONE;
    rx_d_cmd = bus.rx_valid && (bus.rx_data == CH_D);

    unique case (state_q)
      S_DRST: begin
        if (rc_q == RC_LAST) begin
          if (rack_q) begin
            rack_d  = 1'b0;
            txd_d   = CH_K;
            ret_d   = S_IDLE;
            state_d = S_TX_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          rc_d = rc_q + 16'd1;
        end
      end
      S_IDLE: begin
        if (bus.rx_valid) begin
          case (bus.rx_data)
            CH_R: begin
              rc_d    = '0;
              rack_d  = 1'b1;
              state_d = S_DRST;
            end
            CH_O: begin
              cmd_d   = C_RUN;
              state_d = S_CNT_HI;
            end
            CH_S: begin
              cmd_d   = C_SIN;
              state_d = S_CNT_HI;
            end
            CH_G: begin
              cmd_d   = C_SOUT;
              state_d = S_CNT_HI;
            end
            CH_F: begin
              pc_d    = '0;
              stop_d  = 1'b0;
              state_d = S_FREE;
            end
            CH_D: ;
            default: err_d = 1'b1;
          endcase
        end
      end
      S_CNT_HI: begin
        if (bus.rx_valid) begin
          cnt_d   = {bus.rx_data, 8'h00};
          state_d = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (bus.rx_valid) begin
          cnt_d = n_new;
          col_d = '0;
          pc_d  = '0;
          if (n_new == 16'd0) begin
            txd_d   = (cmd_q == C_SOUT) ? CH_NL : CH_K;
            ret_d   = S_IDLE;
            state_d = S_TX_WAIT;
          end else begin
            case (cmd_q)
              C_RUN: state_d = S_RUN;
              C_SIN: state_d = S_SIN_WAIT;
              default: begin
                si_d    = bus.dut_so;
                state_d = S_SOUT_CYC;
              end
            endcase
          end
        end
      end
      S_RUN: begin
        pc_d = pc_inc;
        if (cyc_end) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            txd_d   = CH_K;
            ret_d   = S_IDLE;
            state_d = S_TX_WAIT;
          end
        end
      end
      S_FREE: begin
        pc_d = pc_inc;
        if (rx_d_cmd)
          stop_d = 1'b1;
        if (cyc_end && (stop_q || rx_d_cmd))
          state_d = S_IDLE;
      end
      S_SIN_WAIT: begin
        if (bus.rx_valid) begin
          si_d    = bus.rx_data[NCHAINS-1:0];
          pc_d    = '0;
          state_d = S_SIN_CYC;
        end
      end
      S_SIN_CYC: begin
        pc_d = pc_inc;
        if (cyc_end) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            txd_d   = CH_K;
            ret_d   = S_IDLE;
            state_d = S_TX_WAIT;
          end else begin
            state_d = S_SIN_WAIT;
          end
        end
      end
      S_SOUT_CYC: begin
        pc_d = pc_inc;
        // so is taken just before the rising edge
        if (pc_q == PC_SAMP)
          so_d = bus.dut_so;
        if (cyc_end) begin
          cnt_d   = cnt_q - 16'd1;
          col_d   = col_q + 8'd1;
          txd_d   = hex(so_x);
          ret_d   = S_SOUT_NEXT;
          state_d = S_TX_WAIT;
        end
      end
      S_SOUT_NEXT: begin
        if (col_q == COL_MAX) begin
          col_d   = '0;
          txd_d   = CH_NL;
          ret_d   = S_SOUT_NEXT;
          state_d = S_TX_WAIT;
        end else if (cnt_q == 16'd0) begin
          txd_d   = CH_NL;
          ret_d   = S_IDLE;
          state_d = S_TX_WAIT;
        end else begin
          pc_d    = '0;
          si_d    = bus.dut_so;
          state_d = S_SOUT_CYC;
        end
      end
      S_TX_WAIT: begin
        if (bus.tx_ready) begin
          txs_d   = 1'b1;
          state_d = S_TX_HOLD;
        end
      end
      S_TX_HOLD: begin
        if (!bus.tx_ready) begin
          txs_d   = 1'b0;
          state_d = S_TX_DONE;
        end
      end
      S_TX_DONE: begin
        if (bus.tx_ready)
          state_d = ret_q;
      end
      default: state_d = S_IDLE;
    endcase

    cyc_st = state_d inside
      {S_RUN, S_FREE, S_SIN_CYC, S_SOUT_CYC};
    dclk_d  = cyc_st && (pc_d >= PC_HI);
    drstn_d = (state_d != S_DRST);
    se_d    = !(state_d inside {S_RUN, S_FREE});
    tm_d    = se_d;
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_DRST;
      ret_q   <= S_IDLE;
      cmd_q   <= C_RUN;
      cnt_q   <= '0;
      rc_q    <= '0;
      pc_q    <= '0;
      col_q   <= '0;
      so_q    <= '0;
      stop_q  <= 1'b0;
      rack_q  <= 1'b0;
      txd_q   <= '0;
      txs_q   <= 1'b0;
      dclk_q  <= 1'b0;
      drstn_q <= 1'b0;
      se_q    <= 1'b1;
      tm_q    <= 1'b1;
      si_q    <= '0;
      busy_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      rc_q    <= rc_d;
      pc_q    <= pc_d;
      col_q   <= col_d;
      so_q    <= so_d;
      stop_q  <= stop_d;
      rack_q  <= rack_d;
      txd_q   <= txd_d;
      txs_q   <= txs_d;
      dclk_q  <= dclk_d;
      drstn_q <= drstn_d;
      se_q    <= se_d;
      tm_q    <= tm_d;
      si_q    <= si_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.tx_data  = txd_q;
  assign bus.tx_start = txs_q;
  assign bus.dut_clk  = dclk_q;
  assign bus.dut_rstn = drstn_q;
  assign bus.dut_se   = se_q;
  assign bus.dut_tm   = tm_q;
  assign bus.dut_si   = si_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Bench for scan_test_ctrl: UART byte stimulus, tx scoreboard,
// dut_clk edge and scan-in monitors.
module tb_scan_test_ctrl;

  localparam int NC = 2;
  localparam int CD = 2;
  localparam int MC = 2;
  localparam int RC = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  scan_test_ctrl_if #(.NCHAINS(NC)) bus();

  scan_test_ctrl #(
    .NCHAINS(NC), .CLK_DIV(CD),
    .MAX_COLS(MC), .RST_CYCLES(RC)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] sb[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int rises       = 0;
  int se_hi_rises = 0;
  logic [NC-1:0] si_log[$];

  always @(posedge bus.dut_clk) begin
    rises++;
    si_log.push_back(bus.dut_si);
    if (bus.dut_se) se_hi_rises++;
  end

  int rl_cnt    = 0;
  int err_cnt   = 0;
  int se_lo_cnt = 0;

  always @(negedge clk) begin
    if (!bus.dut_rstn) rl_cnt++;
    if (bus.err) err_cnt++;
    if (!bus.dut_se) se_lo_cnt++;
  end

  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rstn && bus.tx_start && bus.tx_ready) begin
        if (sb.size() == 0)
          chk("tx_unexp", {24'h0, bus.tx_data}, 32'h100);
        else
          chk("tx", {24'h0, bus.tx_data},
              {24'h0, sb.pop_front()});
        bus.tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        bus.tx_ready = 1'b1;
      end
    end
  end

  logic [NC-1:0] so_seq[$];
  logic so_kick = 1'b0;

  initial begin
    bus.dut_so = '0;
    forever begin
      @(posedge bus.dut_clk or posedge so_kick);
      #1;
      if (so_seq.size() > 0)
        bus.dut_so = so_seq.pop_front();
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((bus.busy || sb.size() != 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_to"}, 32'(n < 4000), 32'd1);
  endtask

  int r0, r1, s0, h0, e0, l0, n0, n;
  logic [7:0] sin_b[3];

  initial begin
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst_tx_data",  32'(bus.tx_data),  32'd0);
    chk("rst_dut_clk",  32'(bus.dut_clk),  32'd0);
    chk("rst_dut_rstn", 32'(bus.dut_rstn), 32'd0);
    chk("rst_se",       32'(bus.dut_se),   32'd1);
    chk("rst_tm",       32'(bus.dut_tm),   32'd1);
    chk("rst_si",       32'(bus.dut_si),   32'd0);
    chk("rst_busy",     32'(bus.busy),     32'd1);
    chk("rst_err",      32'(bus.err),      32'd0);

    @(negedge clk);
    rstn = 1'b1;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.dut_rstn) break;
    end
    chk("drst_len", 32'(n), 32'(RC));
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy),   32'd0);
    chk("idle_se",   32'(bus.dut_se), 32'd1);
    chk("idle_tm",   32'(bus.dut_tm), 32'd1);

    r0 = rises; s0 = se_lo_cnt; h0 = se_hi_rises;
    sb.push_back(8'h4B);
    send(8'h6F); send(8'h00); send(8'h05);
    wait_done("run5");
    chk("run5_rises", 32'(rises - r0), 32'd5);
    chk("run5_selow", 32'(se_lo_cnt - s0), 32'(5*2*CD));
    chk("run5_sehi",  32'(se_hi_rises - h0), 32'd0);
    chk("run5_clk",   32'(bus.dut_clk), 32'd0);
    chk("run5_se",    32'(bus.dut_se),  32'd1);

    r0 = rises;
    sb.push_back(8'h4B);
    send(8'h6F); send(8'h00); send(8'h00);
    wait_done("run0");
    chk("run0_rises", 32'(rises - r0), 32'd0);

    e0 = err_cnt;
    send(8'h78);
    repeat (3) @(negedge clk);
    chk("err_x",   32'(err_cnt - e0), 32'd1);
    chk("err_bsy", 32'(bus.busy), 32'd0);
    send(8'h64);
    repeat (3) @(negedge clk);
    chk("err_d",   32'(err_cnt - e0), 32'd1);

    l0 = rl_cnt;
    sb.push_back(8'h4B);
    send(8'h72);
    wait_done("rcmd");
    chk("rcmd_len", 32'(rl_cnt - l0), 32'(RC));

    sin_b = '{8'h01, 8'hF2, 8'h03};
    n0 = si_log.size(); r0 = rises;
    sb.push_back(8'h4B);
    send(8'h73); send(8'h00); send(8'h03);
    for (int i = 0; i < 3; i++) begin
      send(sin_b[i]);
      repeat (6) @(negedge clk);
    end
    wait_done("sin");
    chk("sin_rises", 32'(rises - r0), 32'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("sin_si%0d", i),
          32'(si_log[n0+i]), 32'(i+1));

    so_seq = '{2'd3, 2'd0, 2'd1};
    so_kick = 1'b1;
    @(negedge clk);
    so_kick = 1'b0;
    n0 = si_log.size(); r0 = rises;
    sb.push_back(8'h33); sb.push_back(8'h30);
    sb.push_back(8'h0A); sb.push_back(8'h31);
    sb.push_back(8'h0A);
    send(8'h67); send(8'h00); send(8'h03);
    wait_done("sout");
    chk("sout_rises", 32'(rises - r0), 32'd3);
    chk("sout_si0", 32'(si_log[n0]),   32'd3);
    chk("sout_si1", 32'(si_log[n0+1]), 32'd0);
    chk("sout_si2", 32'(si_log[n0+2]), 32'd1);

    r0 = rises;
    send(8'h66);
    n = 0;
    while (!bus.dut_clk && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("free_hi", 32'(bus.dut_clk), 32'd1);
    send(8'h64);
    wait_done("free");
    chk("free_clk", 32'(bus.dut_clk), 32'd0);
    chk("free_se",  32'(bus.dut_se),  32'd1);
    chk("free_ran", 32'(rises > r0),  32'd1);
    r1 = rises;
    repeat (10) @(negedge clk);
    chk("free_stop", 32'(rises - r1), 32'd0);

    send(8'h67); send(8'h00); send(8'h10);
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("ab_clk",   32'(bus.dut_clk),  32'd0);
    chk("ab_rstn",  32'(bus.dut_rstn), 32'd0);
    chk("ab_busy",  32'(bus.busy),     32'd1);
    chk("ab_start", 32'(bus.tx_start), 32'd0);
    chk("ab_se",    32'(bus.dut_se),   32'd1);
    chk("ab_si",    32'(bus.dut_si),   32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wait_done("rel2");
    chk("rel2_rstn", 32'(bus.dut_rstn), 32'd1);

    r0 = rises;
    sb.push_back(8'h4B);
    send(8'h6F); send(8'h00); send(8'h01);
    wait_done("run1");
    chk("run1_rises", 32'(rises - r0), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
